seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 239 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on request and result.
//
// Single-cycle ops (add/sub/logic/shift/compare) finish one cycle after they
// are accepted. MULU/MUL use a shift-add loop of WIDTH cycles. DIVU/DIV use a
// restoring divider of WIDTH cycles plus one sign-fixup cycle.
//
// Build option: define SEQ_ALU_DIV_EN to include the divider. When it is not
// defined, the divide codes behave like unlisted codes (single-cycle, Z=0,
// Zhi=0).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   request valid            in_ready   block idle, will accept
//   A, B       operands                 ALUFun     operation code
//   Sign       signed compare for lt
//   out_valid  result valid             out_ready  consumer takes result
//   Z          primary result           Zhi        high product / remainder
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, in_ready=1
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DFIX   | apply result signs, divide-by-zero and overflow cases
// DONE   | result held on Z/Zhi with out_valid=1 until out_ready
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Zhi
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can be loaded with WIDTH itself.
  localparam int CW  = SHW + 1;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DFIX, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   opb_q;
  logic               sgn_q;
  logic [WIDTH-1:0]   z_q;
  logic [WIDTH-1:0]   zhi_q;
  logic               in_ready_q;
  logic               out_valid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign Zhi       = zhi_q;

  logic [SHW-1:0] sh;
  logic           is_mul;
  assign sh     = A[SHW-1:0];
  assign is_mul = (ALUFun[5:1] == 5'b00100);

  logic [WIDTH-1:0] alu_z;
  always_comb begin
    alu_z = '0;
    case (ALUFun)
      6'b000000: alu_z = A + B;
      6'b000001: alu_z = A - B;
      6'b011000: alu_z = A & B;
      6'b011110: alu_z = A | B;
      6'b010110: alu_z = A ^ B;
      6'b010001: alu_z = ~(A | B);
      6'b011010: alu_z = A;
      6'b100000: alu_z = B << sh;
      6'b100001: alu_z = B >> sh;
      6'b100011: alu_z = WIDTH'($signed(B) >>> sh);
      6'b110011: alu_z[0] = (A == B);
      6'b110001: alu_z[0] = (A != B);
      6'b110101: alu_z[0] = Sign ? ($signed(A) < $signed(B)) : (A < B);
      6'b111101: alu_z[0] = A[WIDTH-1] | (A == '0);
      6'b111011: alu_z[0] = A[WIDTH-1];
      6'b111111: alu_z[0] = ~A[WIDTH-1] & (A != '0);
      default:   alu_z = '0;
    endcase
  end

  // Signed multiply: the multiplicand is sign-extended, and the partial
  // product for the multiplier's sign bit (last iteration) is subtracted.
  logic [2*WIDTH-1:0] mul_pp;
  logic [2*WIDTH-1:0] mul_acc;
  always_comb begin
    mul_pp  = opb_q[0] ? mcand_q : '0;
    mul_acc = (sgn_q && cnt_q == CW'(1)) ? (acc_q - mul_pp) : (acc_q + mul_pp);
  end

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             is_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] fix_z;
  logic [WIDTH-1:0] fix_zhi;
  logic [WIDTH-1:0] min_neg;

  assign is_div  = (ALUFun[5:1] == 5'b00101);
  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  // Magnitudes; negating the most negative value yields 2^(WIDTH-1) unsigned.
  assign a_mag   = (ALUFun[0] && A[WIDTH-1]) ? (-A) : A;
  assign b_mag   = (ALUFun[0] && B[WIDTH-1]) ? (-B) : B;

  // Dividend bits shift out of opb_q MSB-first while quotient bits shift in.
  always_comb begin
    rem_sh  = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {opb_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    fix_z   = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (-opb_q) : opb_q;
    fix_zhi = (sgn_q && a_q[WIDTH-1]) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    if (b_q == '0) begin
      fix_z   = '1;
      fix_zhi = a_q;
    end else if (sgn_q && a_q == min_neg && b_q == '1) begin
      fix_z   = a_q;
      fix_zhi = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      opb_q       <= '0;
      sgn_q       <= 1'b0;
      z_q         <= '0;
      zhi_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      a_q         <= '0;
      b_q         <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            sgn_q      <= ALUFun[0];
            if (is_mul) begin
              state_q <= S_MUL;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= '0;
              mcand_q <= ALUFun[0] ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
              opb_q   <= B;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (is_div) begin
              state_q <= S_DIV;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= '0;
              mcand_q <= {{WIDTH{1'b0}}, b_mag};
              opb_q   <= a_mag;
              a_q     <= A;
              b_q     <= B;
            end
`endif
            else begin
              state_q     <= S_DONE;
              z_q         <= alu_z;
              zhi_q       <= '0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q   <= mul_acc;
          mcand_q <= mcand_q << 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            z_q         <= mul_acc[WIDTH-1:0];
            zhi_q       <= mul_acc[2*WIDTH-1:WIDTH];
            out_valid_q <= 1'b1;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          acc_q[WIDTH-1:0] <= rem_nxt;
          opb_q            <= quo_nxt;
          cnt_q            <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DFIX;
        end
        S_DFIX: begin
          state_q     <= S_DONE;
          z_q         <= fix_z;
          zhi_q       <= fix_zhi;
          out_valid_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DLAT = DIV_ON ? W + 2 : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, Sign;
  logic [W-1:0] A, B, Z, Zhi;
  logic [5:0]   ALUFun;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, Sign8;
  logic [7:0]   A8, B8, Z8, Zhi8;
  logic [5:0]   ALUFun8;

  seq_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign), .out_valid(out_valid),
    .out_ready(out_ready), .Z(Z), .Zhi(Zhi)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .ALUFun(ALUFun8), .Sign(Sign8), .out_valid(out_valid8),
    .out_ready(out_ready8), .Z(Z8), .Zhi(Zhi8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: results from plain arithmetic on the operation meaning.
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] z, output logic [31:0] zhi,
                                    output int lat);
    longint p;
    int sa, sb;
    z = 0; zhi = 0; lat = 1; p = 0;
    sa = a; sb = b;
    case (op)
      6'b000000: z = a + b;
      6'b000001: z = a - b;
      6'b011000: z = a & b;
      6'b011110: z = a | b;
      6'b010110: z = a ^ b;
      6'b010001: z = ~(a | b);
      6'b011010: z = a;
      6'b100000: z = b << a[4:0];
      6'b100001: z = b >> a[4:0];
      6'b100011: z = 32'(sb >>> a[4:0]);
      6'b110011: z = (a == b) ? 1 : 0;
      6'b110001: z = (a != b) ? 1 : 0;
      6'b110101: z = s ? ((sa < sb) ? 1 : 0) : ((a < b) ? 1 : 0);
      6'b111101: z = (sa <= 0) ? 1 : 0;
      6'b111011: z = (sa < 0) ? 1 : 0;
      6'b111111: z = (sa > 0) ? 1 : 0;
      6'b001000: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        {zhi, z} = p; lat = W + 1;
      end
      6'b001001: begin
        p = longint'(sa) * longint'(sb);
        {zhi, z} = p; lat = W + 1;
      end
      6'b001010, 6'b001011: begin
        if (DIV_ON) begin
          lat = W + 2;
          if (b == 0) begin z = 32'hFFFFFFFF; zhi = a; end
          else if (op == 6'b001010) begin z = a / b; zhi = a % b; end
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin z = a; zhi = 0; end
          else begin z = sa / sb; zhi = sa % sb; end
        end
      end
      default: begin z = 0; zhi = 0; end
    endcase
  endfunction

  // Issue one request, wait (bounded) for the result, then consume it.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input bit scramble, output logic [31:0] gz,
                       output logic [31:0] gzhi, output int lat, output logic acc_ok,
                       output logic idle_ok);
    @(negedge clk);
    acc_ok = in_ready;
    ALUFun = op; A = a; B = b; Sign = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        A = $urandom; B = $urandom; ALUFun = 6'($urandom); Sign = 1'($urandom);
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    gz = Z; gzhi = Zhi;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle_ok = in_ready & ~out_valid;
  endtask

  task automatic do_op8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output int lat);
    @(negedge clk);
    ALUFun8 = op; A8 = a; B8 = b; Sign8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {Zhi8, Z8};
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] ez;
    logic [31:0] ezhi;
    int          elat;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] codes[20];
  logic [31:0] corners[6];
  logic [31:0] gz, gzhi, mz, mzhi, ra, rb;
  logic [15:0] r8;
  logic [5:0]  rop;
  logic        rs, acc_ok, idle_ok;
  int          lat, mlat;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    codes = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001, 6'b011010,
              6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001, 6'b110101, 6'b111101,
              6'b111011, 6'b111111, 6'b001000, 6'b001001, 6'b001010, 6'b001011};
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000002};

    vecs.push_back('{6'b000000, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b000001, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 32'h0, 1});
    vecs.push_back('{6'b011000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 32'h0, 1});
    vecs.push_back('{6'b011110, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 32'hFFFFF0F0, 32'h0, 1});
    vecs.push_back('{6'b010110, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 32'h0, 1});
    vecs.push_back('{6'b010001, 32'h0F0F0F0F, 32'hF0F00000, 1'b0, 32'h0000F0F0, 32'h0, 1});
    vecs.push_back('{6'b011010, 32'h12345678, 32'h9, 1'b0, 32'h12345678, 32'h0, 1});
    vecs.push_back('{6'b100000, 32'h4, 32'h1, 1'b0, 32'h10, 32'h0, 1});
    vecs.push_back('{6'b100000, 32'h24, 32'h1, 1'b0, 32'h10, 32'h0, 1});
    vecs.push_back('{6'b100001, 32'h4, 32'h80000000, 1'b0, 32'h08000000, 32'h0, 1});
    vecs.push_back('{6'b100011, 32'h4, 32'h80000000, 1'b0, 32'hF8000000, 32'h0, 1});
    vecs.push_back('{6'b100011, 32'h1F, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b110011, 32'h5, 32'h5, 1'b0, 32'h1, 32'h0, 1});
    vecs.push_back('{6'b110001, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b110101, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 32'h0, 1});
    vecs.push_back('{6'b110101, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b111101, 32'h0, 32'h0, 1'b0, 32'h1, 32'h0, 1});
    vecs.push_back('{6'b111101, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b111011, 32'h80000000, 32'h0, 1'b0, 32'h1, 32'h0, 1});
    vecs.push_back('{6'b111111, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b111111, 32'h7FFFFFFF, 32'h0, 1'b0, 32'h1, 32'h0, 1});
    vecs.push_back('{6'b001001, 32'hFFFFFFFD, 32'h7, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 33});
    vecs.push_back('{6'b001000, 32'hFFFFFFFD, 32'h7, 1'b0, 32'hFFFFFFEB, 32'h00000006, 33});
    vecs.push_back('{6'b000010, 32'h5, 32'h6, 1'b0, 32'h0, 32'h0, 1});
    vecs.push_back('{6'b001010, 32'h9, 32'h3, 1'b0, DIV_ON ? 32'h3 : 32'h0, 32'h0, DLAT});
    vecs.push_back('{6'b001011, 32'hFFFFFFF9, 32'h2, 1'b0,
                     DIV_ON ? 32'hFFFFFFFD : 32'h0, DIV_ON ? 32'hFFFFFFFF : 32'h0, DLAT});
    vecs.push_back('{6'b001010, 32'd100, 32'h0, 1'b0,
                     DIV_ON ? 32'hFFFFFFFF : 32'h0, DIV_ON ? 32'd100 : 32'h0, DLAT});
    vecs.push_back('{6'b001011, 32'h80000000, 32'hFFFFFFFF, 1'b0,
                     DIV_ON ? 32'h80000000 : 32'h0, 32'h0, DLAT});

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUFun = '0; Sign = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; ALUFun8 = '0; Sign8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_z", {Zhi, Z}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, gz, gzhi, lat, acc_ok, idle_ok);
      chk($sformatf("vec%0d_accept", i), 64'(acc_ok), 64'd1);
      chk($sformatf("vec%0d_z", i), 64'(gz), 64'(vecs[i].ez));
      chk($sformatf("vec%0d_zhi", i), 64'(gzhi), 64'(vecs[i].ezhi));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].elat));
      chk($sformatf("vec%0d_idle", i), 64'(idle_ok), 64'd1);
    end

    // Result held while the consumer stalls; requests ignored meanwhile.
    @(negedge clk);
    ALUFun = 6'b001001; A = 32'hFFFFFFFD; B = 32'h7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", 64'(lat), 64'd33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; A = $urandom; ALUFun = 6'b000000;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_res", k), {Zhi, Z}, 64'hFFFFFFFF_FFFFFFEB);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release_ready", 64'(in_ready), 64'd1);
    chk("stall_release_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    ALUFun = 6'b001000; A = 32'h12345; B = 32'h6789; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midmul_busy", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("midmul_rst_ready", 64'(in_ready), 64'd1);
    chk("midmul_rst_valid", 64'(out_valid), 64'd0);
    chk("midmul_rst_res", {Zhi, Z}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(6'b000000, 32'd2, 32'd3, 1'b0, 1'b0, gz, gzhi, lat, acc_ok, idle_ok);
    chk("post_rst_accept", 64'(acc_ok), 64'd1);
    chk("post_rst_add", {gzhi, gz}, 64'd5);
    chk("post_rst_lat", 64'(lat), 64'd1);

    // Randomized ops against the reference model, inputs scrambled while busy.
    for (int n = 0; n < 150; n++) begin
      int ci;
      ci = $urandom_range(0, 20);
      rop = (ci == 20) ? 6'($urandom) : codes[ci];
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      rs = 1'($urandom);
      ref_model(rop, ra, rb, rs, mz, mzhi, mlat);
      do_op(rop, ra, rb, rs, 1'b1, gz, gzhi, lat, acc_ok, idle_ok);
      chk($sformatf("rnd%0d_op%b_accept", n, rop), 64'(acc_ok), 64'd1);
      chk($sformatf("rnd%0d_op%b_a%h_b%h_res", n, rop, ra, rb), {gzhi, gz}, {mzhi, mz});
      chk($sformatf("rnd%0d_op%b_lat", n, rop), 64'(lat), 64'(mlat));
    end

    // Narrow instance.
    do_op8(6'b001000, 8'hFF, 8'hFF, r8, lat);
    chk("w8_mulu_res", 64'(r8), 64'hFE01);
    chk("w8_mulu_lat", 64'(lat), 64'd9);
    do_op8(6'b001001, 8'hFF, 8'hFF, r8, lat);
    chk("w8_mul_res", 64'(r8), 64'h0001);
    do_op8(6'b001001, 8'h80, 8'h7F, r8, lat);
    chk("w8_mul_neg", 64'(r8), 64'hC080);
    do_op8(6'b000000, 8'hFF, 8'h01, r8, lat);
    chk("w8_add_wrap", 64'(r8), 64'h0000);
    chk("w8_add_lat", 64'(lat), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
